snd_c: RTL and testbench

//  Byte-frame transmitter feeding the rcv_c input interface (valid, 8-bit data, last).

---
 rtl/snd_c.sv | 147 ++++++++++++++
 tb/tb_snd_c.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_c.sv
// Store-and-forward byte-frame transmitter: host bytes are buffered, whole frames sent on a valid/ready link.
// Latency: a 1-byte frame written with the FSM idle and the FIFO empty is presented on the link 2 cycles later.
// Backpressure: link data/last are held while valid is high and ready is low; host writes while full are dropped.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   snd_c_in1/2/3       host write enable / data / last (byte ends a frame)
//   snd_c_in4           link ready from the receiver
//   snd_c_out1/2/3      link valid / data / last
//   snd_c_out4          FIFO full (registered occupancy == DEPTH)
module snd_c #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       snd_c_in1,
    input  logic [7:0] snd_c_in2,
    input  logic       snd_c_in3,
    input  logic       snd_c_in4,
    output logic       snd_c_out1,
    output logic [7:0] snd_c_out2,
    output logic       snd_c_out3,
    output logic       snd_c_out4
);

    // Gap counter runs 0..GAP_CYC-1; keep it at least one bit wide so GAP_CYC of 0 or 1 still elaborates.
    localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [GW-1:0] GAP_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [GW-1:0] GAP_END  = GW'(GAP_LAST);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic [AW:0]   frame_cnt;
    logic [GW-1:0] gap_cnt;
    state_t        state;
    state_t        state_nxt;

    logic       full;
    logic       empty;
    logic       wr_acc;
    logic       pop;
    logic [8:0] head;
    logic       frame_in;
    logic       frame_out;

    assign full  = (occ == CNT_FULL);
    assign empty = (occ == '0);
    assign head  = mem[rd_ptr];

    // Full is judged on registered occupancy, so a write while full is lost even if a pop frees a slot this cycle.
    assign wr_acc    = snd_c_in1 && !full;
    assign pop       = snd_c_out1 && snd_c_in4;
    assign frame_in  = wr_acc && snd_c_in3;
    assign frame_out = pop && head[8];

    assign snd_c_out1 = (state == ST_SEND) && !empty;
    assign snd_c_out2 = snd_c_out1 ? head[7:0] : 8'h00;
    assign snd_c_out3 = snd_c_out1 && head[8];
    assign snd_c_out4 = full;

    // Storage array carries no reset: pointers and occupancy define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= {snd_c_in3, snd_c_in2};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            frame_cnt <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, pop})
                2'b10:   occ <= occ + CNT_ONE;
                2'b01:   occ <= occ - CNT_ONE;
                default: occ <= occ;
            endcase
            case ({frame_in, frame_out})
                2'b10:   frame_cnt <= frame_cnt + CNT_ONE;
                2'b01:   frame_cnt <= frame_cnt - CNT_ONE;
                default: frame_cnt <= frame_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_GAP && state_nxt == ST_GAP) begin
                gap_cnt <= gap_cnt + GAP_ONE;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // A full FIFO with no complete frame starts sending anyway (cut-through); otherwise an over-long
    // frame could never drain and the host would stall forever.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (frame_cnt != '0 || full) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (frame_out) begin
                    state_nxt = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_END) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_snd_c.sv
// Bench for snd_c: directed frame scenarios followed by random host/link traffic.
// Expected link traffic comes from a queue model of the host writes plus the framing rules.
// Link ready is driven by the bench, so backpressure is exercised both directed and randomly.
module tb_snd_c;

    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int GAP_CYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_vld = 1'b0;
    logic [7:0] host_dat = 8'h00;
    logic       host_last = 1'b0;
    logic       lnk_rdy = 1'b0;
    logic       lnk_vld;
    logic [7:0] lnk_dat;
    logic       lnk_last;
    logic       fifo_full;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [8:0] q[$];
    bit         mid = 1'b0;
    int         gap_left = 0;
    bit         hold = 1'b0;
    logic [8:0] held = '0;
    int         n_pop = 0;
    bit         acc = 1'b0;

    // Values sampled in the most recent cycle
    logic       o1, o3, o4;
    logic [7:0] o2;

    snd_c #(.DEPTH(DEPTH), .AW(AW), .GAP_CYC(GAP_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .snd_c_in1  (host_vld),
        .snd_c_in2  (host_dat),
        .snd_c_in3  (host_last),
        .snd_c_in4  (lnk_rdy),
        .snd_c_out1 (lnk_vld),
        .snd_c_out2 (lnk_dat),
        .snd_c_out3 (lnk_last),
        .snd_c_out4 (fifo_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit has_last();
        foreach (q[i]) begin
            if (q[i][8]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock cycle: sample at the falling edge, check against the model, advance the model
    // by what the coming rising edge does, then return just after that edge.
    task automatic cyc();
        logic [8:0] hd;
        int         sz0;
        @(negedge clk);
        o1 = lnk_vld; o2 = lnk_dat; o3 = lnk_last; o4 = fifo_full;
        sz0 = q.size();
        chk("full_flag", o4, sz0 == DEPTH);
        if (!o1) chk("idle_outputs", {o3, o2}, 9'h000);
        if (gap_left > 0) begin
            chk("frame_gap", o1, 1'b0);
            gap_left--;
        end
        if (hold) begin
            chk("hold_vld", o1, 1'b1);
            chk("hold_dat", {o3, o2}, held);
        end
        if (o1) begin
            chk("vld_has_data", sz0 != 0, 1'b1);
            if (!mid) chk("store_fwd", has_last() || sz0 == DEPTH, 1'b1);
        end
        if (o1 && lnk_rdy && sz0 > 0) begin
            hd = q.pop_front();
            chk("pop_dat", {o3, o2}, hd);
            n_pop++;
            mid = !hd[8];
            if (hd[8]) gap_left = GAP_CYC + 1;
        end
        hold = o1 && !lnk_rdy;
        held = {o3, o2};
        acc  = host_vld && (sz0 < DEPTH);
        if (acc) q.push_back({host_last, host_dat});
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        host_vld = 1'b1; host_dat = d; host_last = l;
        cyc();
        host_vld = 1'b0; host_last = 1'b0;
    endtask

    // Empty the DUT: terminate any open frame with a last byte, then let everything go out.
    task automatic drain();
        lnk_rdy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            if ((q.size() != 0 || mid) && !has_last()) begin
                host_vld = 1'b1; host_dat = 8'hEE; host_last = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    cyc();
                    if (acc) break;
                end
                host_vld = 1'b0; host_last = 1'b0;
            end
            for (int i = 0; i < 200 && q.size() != 0; i++) cyc();
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_closed", mid, 1'b0);
        repeat (GAP_CYC + 2) cyc();
    endtask

    initial begin
        int zeros;
        int p0;

        // Reset state
        #12;
        chk("rst_vld", lnk_vld, 1'b0);
        chk("rst_dat", lnk_dat, 8'h00);
        chk("rst_last", lnk_last, 1'b0);
        chk("rst_full", fifo_full, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single two-byte frame: first valid two cycles after the last write
        lnk_rdy = 1'b1;
        push(8'hA5, 1'b0);
        push(8'h3C, 1'b1);
        cyc();
        chk("lat_n1_vld", o1, 1'b0);
        cyc();
        chk("lat_n2_vld", o1, 1'b1);
        chk("lat_n2_dat", o2, 8'hA5);
        chk("lat_n2_last", o3, 1'b0);
        cyc();
        chk("lat_n3_dat", o2, 8'h3C);
        chk("lat_n3_last", o3, 1'b1);
        drain();

        // Backpressure: hold 0x11 for three cycles with ready low
        lnk_rdy = 1'b0;
        push(8'h11, 1'b1);
        cyc();
        chk("bp_n1_vld", o1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold_vld", o1, 1'b1);
            chk("bp_hold_dat", o2, 8'h11);
        end
        lnk_rdy = 1'b1;
        p0 = n_pop;
        cyc();
        chk("bp_pop_dat", o2, 8'h11);
        cyc();
        chk("bp_after_vld", o1, 1'b0);
        chk("bp_pop_count", n_pop - p0, 1);
        drain();

        // Full FIFO, dropped ninth write, cut-through, resume on a later last byte
        lnk_rdy = 1'b0;
        for (int i = 0; i < 9; i++) push(8'h90 + 8'(i), 1'b0);
        chk("full_after8", o4, 1'b1);
        cyc();
        chk("full_held", o4, 1'b1);
        lnk_rdy = 1'b1;
        p0 = n_pop;
        for (int i = 0; i < 12; i++) cyc();
        chk("ct_pop_count", n_pop - p0, 8);
        chk("ct_empty_vld", o1, 1'b0);
        chk("ct_model_empty", q.size(), 0);
        push(8'h99, 1'b1);
        for (int i = 0; i < 10 && q.size() != 0; i++) cyc();
        chk("ct_resume", n_pop - p0, 9);
        drain();

        // Gap between two queued one-byte frames
        lnk_rdy = 1'b0;
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        o1 = 1'b0;
        for (int i = 0; i < 10 && !o1; i++) cyc();
        chk("gap_ready", o1, 1'b1);
        lnk_rdy = 1'b1;
        cyc();
        chk("gap_first", o2, 8'h01);
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (o1) break;
            zeros++;
        end
        chk("gap_len", zeros, GAP_CYC + 1);
        chk("gap_second", o2, 8'h02);
        drain();

        // Push and pop in the same cycle at occupancy 4, both carrying last
        lnk_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h61 + 8'(i), 1'b1);
        lnk_rdy = 1'b1;
        push(8'h65, 1'b1);
        lnk_rdy = 1'b0;
        cyc();
        chk("pp_not_full", o4, 1'b0);
        for (int i = 0; i < 4; i++) push(8'h71 + 8'(i), 1'b0);
        cyc();
        chk("pp_full", o4, 1'b1);
        lnk_rdy = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        chk("pp_remaining", q.size(), 4);
        chk("pp_idle_vld", o1, 1'b0);
        drain();

        // Reset in the middle of sending a full frame
        lnk_rdy = 1'b0;
        for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i), i == 7);
        cyc();
        cyc();
        chk("mid_vld", o1, 1'b1);
        chk("mid_full", o4, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_vld", lnk_vld, 1'b0);
        chk("arst_dat", lnk_dat, 8'h00);
        chk("arst_last", lnk_last, 1'b0);
        chk("arst_full", fifo_full, 1'b0);
        q.delete();
        mid = 1'b0; gap_left = 0; hold = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        lnk_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("no_stale", o1, 1'b0);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            host_vld  = $urandom_range(0, 99) < 55;
            host_dat  = 8'($urandom);
            host_last = $urandom_range(0, 3) == 0;
            lnk_rdy   = $urandom_range(0, 3) != 0;
            cyc();
        end
        host_vld = 1'b0; host_last = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
